// File: rtl/nios_oci_pkg.sv
// ---------------------------------------------------------------------------
// nios_oci_pkg
// Shared definitions for the Nios II OCI debug monitor RAM:
//   - bit positions of the fields carried in the 38-bit JTAG data word (jdo)
//   - state encoding of the JTAG/CPU access sequencer
// ---------------------------------------------------------------------------
package nios_oci_pkg;

  // jdo field layout
  localparam int JDO_RD_BIT   = 35;
  localparam int JDO_WDATA_HI = 34;
  localparam int JDO_WDATA_LO = 3;
  localparam int JDO_ADDR_LO  = 17;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_JRD     = 2'd1,
    ST_JRD_CAP = 2'd2,
    ST_CRD     = 2'd3
  } state_t;

endpackage

// File: rtl/nios_oci_debug_ram_mem.sv
// ---------------------------------------------------------------------------
// nios_oci_debug_ram_mem
// Single-port synchronous RAM, 2**ADDR_W x 32 bits, byte-lane write enables,
// registered read data (one cycle latency, read-before-write on a write).
// Ports:
//   clk    in            clock
//   addr   in  ADDR_W    word address
//   we     in  1         write enable
//   be     in  4         byte lane enables for a write
//   wdata  in  32        write data
//   q      out 32        read data, valid the cycle after addr is presented
// Contents are not reset and are undefined at power-up.
// ---------------------------------------------------------------------------
module nios_oci_debug_ram_mem #(
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/nios_oci_debug_ram.sv
// ---------------------------------------------------------------------------
// nios_oci_debug_ram
// On-chip debug monitor RAM shared between the JTAG debug path and the CPU.
// JTAG commands arrive as one-cycle take_* pulses with jdo; results return
// through MonDReg / monitor_ready / monitor_error. The CPU reaches the same
// RAM through an Avalon-MM slave. JTAG traffic always wins arbitration.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   jdo[37:0]                    JTAG data word, valid with any take_* pulse
//   take_action_ocimem_a         load address (jdo[17+:ADDR_W]), read if jdo[35]
//   take_action_ocimem_b         write jdo[34:3] at the current address
//   take_no_action_ocimem_a      read at the current address
//   avs_address/read/write/
//   writedata/byteenable         CPU slave request
//   avs_readdata, avs_waitrequest CPU slave response
//   MonDReg                      last JTAG read data
//   monitor_ready                last JTAG operation complete
//   monitor_error                JTAG overrun (pulse dropped)
// ---------------------------------------------------------------------------
import nios_oci_pkg::*;

module nios_oci_debug_ram #(
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  state_t            state;
  logic [ADDR_W-1:0] mon_areg;
  logic              rd_req;
  logic              wr_req;
  logic [31:0]       wdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;

  logic              take_any;
  logic              jtag_busy;
  logic              cpu_slot;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign take_any  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  // A JTAG request is outstanding while latched or while its read is in flight.
  assign jtag_busy = rd_req | wr_req | (state == ST_JRD) | (state == ST_JRD_CAP);

  // The CPU may use the RAM in IDLE only when nothing JTAG is latched or
  // arriving; an arriving pulse blocks the CPU so the JTAG access goes first.
  assign cpu_slot  = (state == ST_IDLE) & ~rd_req & ~wr_req & ~take_any;

  assign avs_waitrequest = ~reset_n |
                           ~((state == ST_CRD) | (cpu_slot & avs_write & ~avs_read));

  // RAM port steering
  always_comb begin
    ram_addr  = mon_areg;
    ram_we    = 1'b0;
    ram_be    = 4'hF;
    ram_wdata = wdata;
    case (state)
      ST_IDLE: begin
        if (wr_req) begin
          ram_we = 1'b1;
        end else if (cpu_slot) begin
          ram_addr = avs_address;
          if (!avs_read && avs_write) begin
            ram_we    = 1'b1;
            ram_be    = avs_byteenable;
            ram_wdata = avs_writedata;
          end
        end
      end
      ST_CRD:  ram_addr = avs_address;
      default: ram_addr = mon_areg;
    endcase
  end

  nios_oci_debug_ram_mem #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // Sequencer plus pulse intake. Intake comes last so an ocimem_a reload
  // overrides any address increment or ready set from the sequencer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      mon_areg      <= '0;
      rd_req        <= 1'b0;
      wr_req        <= 1'b0;
      wdata         <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      avs_readdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_req) begin
            wr_req        <= 1'b0;
            mon_areg      <= mon_areg + 1'b1;
            monitor_ready <= 1'b1;
          end else if (rd_req) begin
            rd_req <= 1'b0;
            state  <= ST_JRD;
          end else if (cpu_slot && avs_read) begin
            state <= ST_CRD;
          end
        end
        ST_JRD: state <= ST_JRD_CAP;
        ST_JRD_CAP: begin
          MonDReg       <= ram_q;
          mon_areg      <= mon_areg + 1'b1;
          monitor_ready <= 1'b1;
          state         <= ST_IDLE;
        end
        ST_CRD: begin
          avs_readdata <= ram_q;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // A coincident ocimem_b / no_action pulse is dropped and flagged.
      if (take_action_ocimem_a) begin
        mon_areg      <= jdo[JDO_ADDR_LO +: ADDR_W];
        monitor_ready <= 1'b0;
        monitor_error <= take_action_ocimem_b | take_no_action_ocimem_a;
        if (!jtag_busy) rd_req <= jdo[JDO_RD_BIT];
      end else if (take_action_ocimem_b || take_no_action_ocimem_a) begin
        if (jtag_busy) begin
          monitor_error <= 1'b1;
        end else begin
          if (take_action_ocimem_b) begin
            wdata  <= jdo[JDO_WDATA_HI:JDO_WDATA_LO];
            wr_req <= 1'b1;
          end
          if (take_no_action_ocimem_a) rd_req <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nios_oci_debug_ram.sv
// ---------------------------------------------------------------------------
// tb_nios_oci_debug_ram
// Self-checking bench for nios_oci_debug_ram. Holds a word-array model of the
// RAM and the JTAG address pointer, drives directed JTAG/CPU sequences with
// random data, and compares DUT outputs against the model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_nios_oci_debug_ram;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [37:0]       jdo = '0;
  logic              take_a = 1'b0;
  logic              take_b = 1'b0;
  logic              take_n = 1'b0;
  logic [ADDR_W-1:0] avs_address = '0;
  logic              avs_read = 1'b0;
  logic              avs_write = 1'b0;
  logic [31:0]       avs_writedata = '0;
  logic [3:0]        avs_byteenable = '0;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [DEPTH];
  int          ref_areg = 0;
  logic [31:0] ref_mondreg = '0;

  nios_oci_debug_ram #(.ADDR_W(ADDR_W), .INIT_FILE("")) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_action_ocimem_b    (take_b),
    .take_no_action_ocimem_a (take_n),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_ocimem_a, 3 = ocimem_a+ocimem_b
  task automatic applyStimulus(input int kind, input logic [ADDR_W-1:0] addr,
                               input logic rd, input logic [31:0] data);
    jdo = '0;
    if (kind == 1) begin
      jdo[34:3] = data;
    end else begin
      jdo[17 +: ADDR_W] = addr;
      jdo[35] = rd;
    end
    take_a = (kind == 0) || (kind == 3);
    take_b = (kind == 1) || (kind == 3);
    take_n = (kind == 2);
    cyc();
    take_a = 1'b0;
    take_b = 1'b0;
    take_n = 1'b0;
    jdo    = '0;
  endtask

  task automatic jtag_load(input logic [ADDR_W-1:0] addr);
    applyStimulus(0, addr, 1'b0, 32'h0);
    ref_areg = addr;
    checkOutput("load_ready_clr", {31'b0, monitor_ready}, 32'h0);
    checkOutput("load_error_clr", {31'b0, monitor_error}, 32'h0);
  endtask

  task automatic jtag_write(input logic [31:0] data);
    applyStimulus(1, '0, 1'b0, data);
    ref_mem[ref_areg] = data;
    ref_areg = (ref_areg + 1) % DEPTH;
    cyc();
  endtask

  task automatic jtag_read(input bit load, input logic [ADDR_W-1:0] addr);
    logic [31:0] exp;
    if (load) begin
      applyStimulus(0, addr, 1'b1, 32'h0);
      ref_areg = addr;
    end else begin
      applyStimulus(2, '0, 1'b0, 32'h0);
    end
    exp = ref_mem[ref_areg];
    ref_areg = (ref_areg + 1) % DEPTH;
    cyc();
    cyc();
    checkOutput("jrd_early_data", MonDReg, ref_mondreg);
    if (load) checkOutput("jrd_early_ready", {31'b0, monitor_ready}, 32'h0);
    cyc();
    checkOutput("jrd_ready", {31'b0, monitor_ready}, 32'h1);
    checkOutput("jrd_data", MonDReg, exp);
    ref_mondreg = exp;
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data, input logic [3:0] be);
    avs_address    = addr;
    avs_writedata  = data;
    avs_byteenable = be;
    avs_write      = 1'b1;
    #1;
    checkOutput("cwr_wait", {31'b0, avs_waitrequest}, 32'h0);
    cyc();
    avs_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) ref_mem[addr][8*i +: 8] = data[8*i +: 8];
    end
  endtask

  task automatic cpu_read(input logic [ADDR_W-1:0] addr);
    int n;
    avs_address = addr;
    avs_read    = 1'b1;
    #1;
    n = 0;
    while (avs_waitrequest && n < 20) begin
      cyc();
      n++;
    end
    checkOutput("crd_wait_cycles", n, 32'd1);
    cyc();
    avs_read = 1'b0;
    checkOutput("crd_data", avs_readdata, ref_mem[addr]);
  endtask

  initial begin
    logic [31:0]       d;
    logic [ADDR_W-1:0] a;
    int                n;

    // Reset: outputs cleared, CPU stalled even for a write.
    avs_write = 1'b1;
    #2;
    checkOutput("rst_wait", {31'b0, avs_waitrequest}, 32'h1);
    checkOutput("rst_mondreg", MonDReg, 32'h0);
    checkOutput("rst_ready", {31'b0, monitor_ready}, 32'h0);
    checkOutput("rst_error", {31'b0, monitor_error}, 32'h0);
    checkOutput("rst_readdata", avs_readdata, 32'h0);
    avs_write = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    cyc();
    cyc();
    checkOutput("idle_mondreg", MonDReg, 32'h0);
    checkOutput("idle_ready", {31'b0, monitor_ready}, 32'h0);
    checkOutput("idle_error", {31'b0, monitor_error}, 32'h0);

    // Seed RAM words used later.
    cpu_write(8'd5, 32'h0, 4'hF);
    cpu_write(8'd0, $urandom, 4'hF);
    cpu_write(8'h30, $urandom, 4'hF);
    cpu_write(8'h50, $urandom, 4'hF);
    cpu_read(8'd5);

    // JTAG writes with ready latency, then load-read and read-next.
    jtag_load(8'h10);
    applyStimulus(1, '0, 1'b0, 32'hDEADBEEF);
    checkOutput("wr_ready_early", {31'b0, monitor_ready}, 32'h0);
    ref_mem[ref_areg] = 32'hDEADBEEF;
    ref_areg = (ref_areg + 1) % DEPTH;
    cyc();
    checkOutput("wr_ready", {31'b0, monitor_ready}, 32'h1);
    jtag_write(32'h12345678);
    jtag_read(1'b1, 8'h10);
    checkOutput("rd_deadbeef", MonDReg, 32'hDEADBEEF);
    jtag_read(1'b0, '0);
    checkOutput("rd_12345678", MonDReg, 32'h12345678);

    // Random JTAG writes read back over both ports.
    for (int i = 0; i < 4; i++) begin
      a = ADDR_W'($urandom_range(8'h60, 8'hF0));
      d = $urandom;
      jtag_load(a);
      jtag_write(d);
      cpu_read(a);
      jtag_read(1'b1, a);
    end

    // Address wrap at the top word.
    jtag_load(ADDR_W'(DEPTH - 1));
    jtag_write($urandom);
    jtag_read(1'b0, '0);
    cpu_read(ADDR_W'(DEPTH - 1));

    // CPU byte-lane write.
    cpu_write(8'd5, 32'hAABBCCDD, 4'b0011);
    cpu_read(8'd5);
    checkOutput("be_const", avs_readdata, 32'h0000CCDD);

    // CPU read arriving with a JTAG write: JTAG first, CPU stalled.
    jtag_load(8'h20);
    d = $urandom;
    jdo[34:3]   = d;
    take_b      = 1'b1;
    avs_address = 8'h20;
    avs_read    = 1'b1;
    #1;
    checkOutput("arb_wait", {31'b0, avs_waitrequest}, 32'h1);
    @(posedge clk);
    #1;
    take_b = 1'b0;
    jdo    = '0;
    ref_mem[8'h20] = d;
    ref_areg = (ref_areg + 1) % DEPTH;
    n = 1;
    while (avs_waitrequest && n < 20) begin
      cyc();
      n++;
    end
    checkOutput("arb_no_timeout", {31'b0, n < 20}, 32'h1);
    checkOutput("arb_stalled", {31'b0, n > 1}, 32'h1);
    checkOutput("arb_jtag_done", {31'b0, monitor_ready}, 32'h1);
    cyc();
    avs_read = 1'b0;
    checkOutput("arb_data", avs_readdata, d);

    // Overrun: ocimem_b right after a read-command ocimem_a.
    applyStimulus(0, 8'h30, 1'b1, 32'h0);
    ref_areg = 8'h30;
    applyStimulus(1, '0, 1'b0, $urandom);
    checkOutput("ovr_error", {31'b0, monitor_error}, 32'h1);
    cyc();
    cyc();
    checkOutput("ovr_read_ready", {31'b0, monitor_ready}, 32'h1);
    checkOutput("ovr_read_data", MonDReg, ref_mem[8'h30]);
    ref_mondreg = ref_mem[8'h30];
    ref_areg = 8'h31;
    cpu_read(8'h30);
    jtag_load(8'h40);

    // Simultaneous ocimem_a and ocimem_b: address loaded, write dropped.
    applyStimulus(3, 8'h50, 1'b0, 32'h0);
    ref_areg = 8'h50;
    checkOutput("dual_error", {31'b0, monitor_error}, 32'h1);
    checkOutput("dual_ready", {31'b0, monitor_ready}, 32'h0);
    cyc();
    cyc();
    cpu_read(8'h50);
    jtag_read(1'b0, '0);
    jtag_load(8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
